bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/bus_arb_mux.sv | 42 ++++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_arb_pkg
// Brief   : Shared arbiter state encoding and default burst limit.
// Revision: 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int c_max_burst_default = 4;

endpackage
`default_nettype wire

// File: rtl/bus_arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : bus_arb_mux
// Brief   : Grant-driven selection of address, write data and strobes.
// Revision: 1.0 - initial release
// ============================================================================
module bus_arb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              i_gnt0,
    input  logic              i_gnt1,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_rd0,
    input  logic              i_rd1,
    input  logic              i_wr0,
    input  logic              i_wr1,
    input  logic [DATA_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata
);

    logic w_act0;
    logic w_act1;

    // A grant cycle whose request has already fallen is an idle bus cycle.
    assign w_act0 = i_gnt0 & i_req0;
    assign w_act1 = i_gnt1 & i_req1;

    // Write wins when a requester asserts both strobes.
    assign o_mem_wr    = (w_act0 & i_wr0) | (w_act1 & i_wr1);
    assign o_mem_rd    = (w_act0 & i_rd0 & ~i_wr0) | (w_act1 & i_rd1 & ~i_wr1);
    assign o_mem_addr  = i_gnt1 ? i_addr1  : i_addr0;
    assign o_mem_wdata = i_gnt1 ? i_wdata1 : i_wdata0;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter
// Brief   : Two-requester round-robin bus arbiter with burst limiting.
// Revision: 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST = c_max_burst_default,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              rd0,
    input  logic              rd1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               c_cnt_w   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_BURST - 1);

    arb_state_t         r_state;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic               r_rr;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               w_burst_last;

    assign w_burst_last = (r_burst_cnt == c_cnt_max);

    // Grants are registered alongside the state so they carry no decode logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_burst_cnt <= '0;
            r_rr        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0 && (!req1 || !r_rr)) begin
                        r_state <= OWN0;
                        r_gnt0  <= 1'b1;
                    end else if (req1) begin
                        r_state <= OWN1;
                        r_gnt1  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!req0 || (req1 && w_burst_last)) begin
                        r_gnt0      <= 1'b0;
                        r_rr        <= 1'b1;
                        r_burst_cnt <= '0;
                        if (req1) begin
                            r_state <= OWN1;
                            r_gnt1  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (!w_burst_last) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                OWN1: begin
                    if (!req1 || (req0 && w_burst_last)) begin
                        r_gnt1      <= 1'b0;
                        r_rr        <= 1'b0;
                        r_burst_cnt <= '0;
                        if (req0) begin
                            r_state <= OWN0;
                            r_gnt0  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (!w_burst_last) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign rdata = mem_rdata;

    bus_arb_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .i_gnt0      (r_gnt0),
        .i_gnt1      (r_gnt1),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_rd0       (rd0),
        .i_rd1       (rd1),
        .i_wr0       (wr0),
        .i_wr1       (wr1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata)
    );

endmodule
`default_nettype wire
